// File: rtl/fpga_uart_reporter_pkg.sv
// Shared FSM state type, ASCII constants and hex-digit helpers for the UART reporter.
package fpga_uart_reporter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_DONE
   } state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   // Character idx of a report line: eight hex digits MSB first, then CR, then LF.
   function automatic logic [7:0] line_char(input logic [31:0] word, input logic [3:0] idx);
      logic [4:0] lsb;
      lsb = {3'd7 - idx[2:0], 2'b00};
      if (idx < 4'd8) begin
         return nibble_to_ascii(word[lsb +: 4]);
      end else if (idx == 4'd8) begin
         return ASCII_CR;
      end else begin
         return ASCII_LF;
      end
   endfunction

endpackage

// File: rtl/fpga_uart_reporter_if.sv
// Reporter bundle: observed word and force request in, serial line and status out.
interface fpga_uart_reporter_if;
   logic [31:0] data_in;
   logic        force_send;
   logic        tx;
   logic        busy;
   logic [15:0] lines_sent;

   modport master (
      output data_in,
      output force_send,
      input  tx,
      input  busy,
      input  lines_sent
   );

   modport slave (
      input  data_in,
      input  force_send,
      output tx,
      output busy,
      output lines_sent
   );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a start pulse on the last stop-bit cycle chains frames with no gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   output logic       done_o,
   output logic       tx_o
);
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       bit_q;
   logic [8:0]       shift_q;
   logic             active_q;
   logic             tx_q;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_LAST);
   // Asserted during the final cycle of the stop bit so the next frame can follow immediately.
   assign done_o  = active_q && bit_end && (bit_q == 4'd9);
   assign tx_o    = tx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
         active_q <= 1'b0;
         tx_q     <= 1'b1;
      end else if (start_i) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= {1'b1, byte_i};
         active_q <= 1'b1;
         tx_q     <= 1'b0;
      end else if (active_q) begin
         if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 4'd9) begin
               active_q <= 1'b0;
               tx_q     <= 1'b1;
            end else begin
               bit_q   <= bit_q + 4'd1;
               tx_q    <= shift_q[0];
               shift_q <= {1'b1, shift_q[8:1]};
            end
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/fpga_uart_reporter.sv
// Reports the observed 32-bit word as an "XXXXXXXX\r\n" line over UART whenever it changes or on request.
module fpga_uart_reporter
   import fpga_uart_reporter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input logic                 clk,
   input logic                 rst,
   fpga_uart_reporter_if.slave bus
);
   localparam int         CHARS_PER_LINE = 10;
   localparam logic [3:0] LAST_CHAR      = 4'(CHARS_PER_LINE - 1);

   state_e      state_q;
   logic [31:0] snap_q;
   logic [31:0] last_q;
   logic        reported_q;
   logic        pend_q;
   logic        busy_q;
   logic [3:0]  char_idx_q;
   logic [7:0]  next_byte_q;
   logic [15:0] lines_q;

   logic        trigger;
   logic        fire;
   logic        ser_start;
   logic [7:0]  ser_byte;
   logic        ser_done;

   assign trigger = !busy_q && (bus.force_send || pend_q || !reported_q || (bus.data_in != last_q));
   assign fire    = (state_q == ST_IDLE) && trigger;
   // The first character is taken straight from data_in so its start bit lands on the cycle after the trigger.
   assign ser_start = fire || ((state_q == ST_SEND) && ser_done && (char_idx_q != LAST_CHAR));
   assign ser_byte  = fire ? nibble_to_ascii(bus.data_in[31:28]) : next_byte_q;

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk    (clk),
      .rst    (rst),
      .start_i(ser_start),
      .byte_i (ser_byte),
      .done_o (ser_done),
      .tx_o   (bus.tx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         snap_q      <= '0;
         last_q      <= '0;
         reported_q  <= 1'b0;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         char_idx_q  <= '0;
         next_byte_q <= '0;
         lines_q     <= '0;
      end else begin
         if (bus.force_send && (state_q != ST_IDLE)) begin
            pend_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (fire) begin
                  snap_q     <= bus.data_in;
                  char_idx_q <= '0;
                  busy_q     <= 1'b1;
                  pend_q     <= 1'b0;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               next_byte_q <= line_char(snap_q, char_idx_q + 4'd1);
               state_q     <= ST_SEND;
            end
            ST_SEND: begin
               if (ser_done) begin
                  if (char_idx_q == LAST_CHAR) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_DONE;
                  end else begin
                     char_idx_q <= char_idx_q + 4'd1;
                     state_q    <= ST_LOAD;
                  end
               end
            end
            ST_DONE: begin
               last_q     <= snap_q;
               reported_q <= 1'b1;
               lines_q    <= lines_q + 16'd1;
               state_q    <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.lines_sent = lines_q;
endmodule

// File: doc/fpga_uart_reporter.md
FPGA_UART_REPORTER -- requirements
Module: fpga_uart_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter CHARS_PER_LINE, fixed 10, meaning 8 hex digits plus CR plus LF; not overridable.
REQ-003 One clock; reset is asynchronous and active-low; ports are named clk and rst.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 data_in  input  32  observed processor output word (the processor's fpga port).
REQ-007 force_send  input  1  single-cycle pulse; request a report even when data_in is unchanged.
REQ-008 tx  output  1  UART serial line, 8N1, idle high.
REQ-009 busy  output  1  high while a line is being transmitted.
REQ-010 lines_sent  output  16  count of completed lines, wraps 0xFFFF->0x0000.

Function
REQ-011 The block SHALL report data_in as ASCII: 8 uppercase hex digits, MSB nibble first, then 0x0D, then 0x0A.
REQ-012 Digit mapping SHALL be nibble 0-9 -> 0x30-0x39 and nibble A-F -> 0x41-0x46.
REQ-013 Each character SHALL be framed as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-014 A line SHALL start when busy=0 and either (data_in != last reported word) or force_send=1 or no word has been reported since reset.
REQ-015 On line start, data_in SHALL be captured into a snapshot register; changes to data_in during transmission SHALL NOT alter the line in flight.
REQ-016 The start bit of the first character SHALL begin on the cycle after the trigger cycle; busy SHALL rise on that same cycle.
REQ-017 Characters SHALL be sent back-to-back with no idle bits between them; one line SHALL last exactly 100*CLKS_PER_BIT cycles.
REQ-018 Top-level FSM states: IDLE, LOAD (select next character), SEND (byte serializer active), DONE.
REQ-019 Transitions: IDLE->LOAD on trigger; LOAD->SEND always; SEND->LOAD when a character completes and char index < 9; SEND->DONE when character index 9 completes; DONE->IDLE always.
REQ-020 In DONE the block SHALL update last reported word := snapshot, increment lines_sent, and clear busy on the following cycle.
REQ-021 force_send asserted while busy=1 SHALL be latched as pending and SHALL start exactly one extra line after the current one; multiple pulses SHALL collapse into one.
REQ-022 If data_in differs from the snapshot at line end, a new line SHALL start from IDLE without any further stimulus.
REQ-023 With data_in stable and no force_send, tx SHALL remain 1 indefinitely after the first line.

Reset
REQ-024 Asserting rst low SHALL immediately, without a clock edge, set tx=1, busy=0, lines_sent=0, FSM=IDLE, character index=0, baud counter=0, pending force cleared, "reported" flag cleared.
REQ-025 Reset mid-frame SHALL abort the frame; the partial character is not resumed; after release, a full line of the current data_in SHALL be sent.
REQ-026 The first trigger after reset release SHALL be evaluated on the first rising clk edge with rst high.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, ASCII_CR=0x0D, ASCII_LF=0x0A, and the nibble-to-ASCII function.
REQ-028 One sub-module, uart_tx_byte (start pulse, 8-bit byte in, done pulse, tx out, CLKS_PER_BIT parameter), SHALL contain the baud counter and bit serializer.
REQ-029 All state SHALL be in flip-flops clocked by clk with asynchronous active-low reset rst; tx SHALL be driven from a register (glitch-free).

Verification (CLKS_PER_BIT=4)
REQ-030 Release reset with data_in=0x0000002A -> bytes 30 30 30 30 30 30 32 41 0D 0A decoded on tx; busy high for 400 cycles; lines_sent=1.
REQ-031 data_in=0xDEADBEEF -> bytes 44 45 41 44 42 45 45 46 0D 0A (uppercase checked).
REQ-032 Change data_in from 0x11111111 to 0x22222222 at cycle 50 of a line -> the first line still reports 31 x8; the second line reports 32 x8 back-to-back; lines_sent=2.
REQ-033 data_in held constant for 2000 cycles after the first line -> tx stays 1, lines_sent stays 1; one force_send pulse -> exactly one identical line is sent.
REQ-034 Pull rst low at cycle 130 of a line -> tx=1 and busy=0 in the same cycle (asynchronous); after release, a complete 10-character line is sent from character 0.
REQ-035 Three force_send pulses during one busy line -> exactly one extra line; lines_sent increments by 2 in total.
